// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter: FSM state encoding
// and the select-width helper.
package mux_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Smallest width that can encode n distinct values (n >= 2).
    function automatic int sel_width(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: rotates the request vector so rr_ptr sits
// at bit 0, then priority-encodes the lowest set bit back into an index.
module rr_pick
    import mux_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = sel_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] rr_ptr,
    output logic [SEL_W-1:0] winner,
    output logic             any_req
);

    localparam logic [SEL_W:0] N_EXT = (SEL_W + 1)'(N);

    logic [2*N-1:0]   dbl;
    logic [N-1:0]     window;
    logic [SEL_W-1:0] offset;
    logic [SEL_W:0]   sum;

    // Doubling the vector makes the wrap from N-1 back to 0 a plain shift.
    assign dbl     = {req, req};
    assign window  = N'(dbl >> rr_ptr);
    assign any_req = |req;

    always_comb begin
        offset = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (window[k]) begin
                offset = SEL_W'(k);
            end
        end
    end

    assign sum    = {1'b0, rr_ptr} + {1'b0, offset};
    assign winner = (sum >= N_EXT) ? SEL_W'(sum - N_EXT) : SEL_W'(sum);

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared N-to-1 mux.
// Optional hold limit enabled by defining ARB_TIMEOUT_EN.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 8,
    localparam int SEL_W    = sel_width(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] sel,
    output logic             sel_vld,
    output logic             timeout
);

    if (N < 2 || MAX_HOLD < 2) begin : g_param_err
        $error("mux_rr_arbiter: N and MAX_HOLD must both be >= 2");
    end

    arb_state_t       state_reg, state_next;
    logic [SEL_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [N-1:0]     gnt_reg, gnt_next;
    logic [SEL_W-1:0] sel_reg, sel_next;
    logic             sel_vld_reg, sel_vld_next;
    logic             timeout_reg, timeout_next;
    logic [SEL_W-1:0] winner;
    logic             any_req;
    logic             hold_expire;

    rr_pick #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_rr_pick (
        .req     (req),
        .rr_ptr  (rr_ptr_reg),
        .winner  (winner),
        .any_req (any_req)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = sel_width(MAX_HOLD);

    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;

    // Counts grant cycles already spent by the current owner.
    always_comb begin
        hold_cnt_next = hold_cnt_reg;
        if (state_reg == ARB_IDLE) begin
            hold_cnt_next = '0;
        end else if (hold_cnt_reg != HOLD_W'(MAX_HOLD - 1)) begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_reg <= '0;
        end else begin
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    assign hold_expire = (hold_cnt_reg == HOLD_W'(MAX_HOLD - 1));
`else
    assign hold_expire = 1'b0;
`endif

    always_comb begin
        state_next   = state_reg;
        rr_ptr_next  = rr_ptr_reg;
        gnt_next     = gnt_reg;
        sel_next     = sel_reg;
        sel_vld_next = sel_vld_reg;
        timeout_next = 1'b0;
        case (state_reg)
            ARB_IDLE: begin
                if (any_req) begin
                    state_next   = ARB_GRANT;
                    gnt_next     = {{(N - 1){1'b0}}, 1'b1} << winner;
                    sel_next     = winner;
                    sel_vld_next = 1'b1;
                    rr_ptr_next  = (winner == SEL_W'(N - 1)) ? '0 : winner + 1'b1;
                end
            end
            ARB_GRANT: begin
                // Release and forced revoke both leave sel at the last owner.
                if (!req[sel_reg]) begin
                    state_next   = ARB_IDLE;
                    gnt_next     = '0;
                    sel_vld_next = 1'b0;
                end else if (hold_expire) begin
                    state_next   = ARB_IDLE;
                    gnt_next     = '0;
                    sel_vld_next = 1'b0;
                    timeout_next = 1'b1;
                end
            end
            default: begin
                state_next   = ARB_IDLE;
                gnt_next     = '0;
                sel_vld_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ARB_IDLE;
            rr_ptr_reg  <= '0;
            gnt_reg     <= '0;
            sel_reg     <= '0;
            sel_vld_reg <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rr_ptr_reg  <= rr_ptr_next;
            gnt_reg     <= gnt_next;
            sel_reg     <= sel_next;
            sel_vld_reg <= sel_vld_next;
            timeout_reg <= timeout_next;
        end
    end

    assign gnt     = gnt_reg;
    assign sel     = sel_reg;
    assign sel_vld = sel_vld_reg;
    assign timeout = timeout_reg;

endmodule
